// File: rtl/shared_regbank.sv
// Multi-channel register bank: NUM_CH req/ack hosts share one flop array through a round-robin arbiter.
// Optional REGBANK_WRPROT_EN: register DEPTH-1 bit0 locks writes to addresses 0..DEPTH-2.
`timescale 1ns/1ps
module shared_regbank #(
  parameter int NUM_CH = 2,
  parameter int DW     = 8,
  parameter int DEPTH  = 256,
  parameter int AW     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    req,
  input  logic [NUM_CH-1:0]    we,
  input  logic [NUM_CH*AW-1:0] addr,
  input  logic [NUM_CH*DW-1:0] wdata,
  output logic [NUM_CH-1:0]    ack,
  output logic [NUM_CH-1:0]    err,
  output logic [NUM_CH*DW-1:0] rdata,
  output logic [15:0]          conflict_cnt
);

  // Handshake: a channel raises req with stable we/addr/wdata and holds it until
  // ack pulses for one cycle; err and rdata are meaningful only while ack is high.

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
`ifdef REGBANK_WRPROT_EN
  localparam logic [AW:0] LOCK_V = (AW+1)'(DEPTH - 1);
`endif

  logic [DW-1:0]     mem [DEPTH];
  logic [CW-1:0]     ptr_q;
  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] grant;
  logic              gnt_vld;
  logic [CW-1:0]     gnt_idx;
  int unsigned       cand;
  int unsigned       n_elig;
  logic              contended;

  logic [AW-1:0]     sel_addr;
  logic [DW-1:0]     sel_wdata;
  logic              sel_we;
  logic [IW-1:0]     mem_idx;
  logic              in_range;
  logic              wr_blocked;
  logic              acc_err;
  logic              do_write;
  logic [DW-1:0]     rd_val;

  logic [NUM_CH-1:0]    ack_q;
  logic [NUM_CH-1:0]    err_q;
  logic [NUM_CH*DW-1:0] rdata_q;
  logic [15:0]          cnt_q;

  // A channel in its ack cycle is masked so a held req is not serviced twice.
  assign elig = req & ~ack_q;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = (int'(ptr_q) + k) % NUM_CH;
      if (!gnt_vld && elig[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = CW'(cand);
      end
    end
  end

  always_comb begin
    grant = '0;
    if (gnt_vld) grant[gnt_idx] = 1'b1;
  end

  always_comb begin
    n_elig = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (elig[k]) n_elig = n_elig + 1;
    end
    contended = (n_elig >= 2);
  end

  assign sel_addr  = addr[gnt_idx*AW +: AW];
  assign sel_wdata = wdata[gnt_idx*DW +: DW];
  assign sel_we    = we[gnt_idx];
  assign mem_idx   = sel_addr[IW-1:0];
  assign in_range  = ({1'b0, sel_addr} < DEPTH_V);

`ifdef REGBANK_WRPROT_EN
  // The lock register itself stays writable so software can always unlock.
  assign wr_blocked = sel_we && mem[DEPTH-1][0] && in_range && ({1'b0, sel_addr} != LOCK_V);
`else
  assign wr_blocked = 1'b0;
`endif

  assign acc_err  = !in_range || wr_blocked;
  assign do_write = gnt_vld && sel_we && !acc_err;
  assign rd_val   = in_range ? mem[mem_idx] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH; j++) mem[j] <= '0;
    end else if (do_write) begin
      mem[mem_idx] <= sel_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= CW'(NUM_CH - 1);
      ack_q   <= '0;
      err_q   <= '0;
      rdata_q <= '0;
    end else begin
      ack_q <= grant;
      err_q <= acc_err ? grant : '0;
      if (gnt_vld) ptr_q <= gnt_idx;
      if (gnt_vld && !sel_we) rdata_q[gnt_idx*DW +: DW] <= rd_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (contended && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign ack          = ack_q;
  assign err          = err_q;
  assign rdata        = rdata_q;
  assign conflict_cnt = cnt_q;

endmodule
